// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int TIMEOUT_CYC_DEF = 32;
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic is_aligned(input logic [2:0] addr_lo);
    return (addr_lo & ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_stage_exmem_reg.sv
// EX/MEM pipeline register: enable-gated capture of the execute-stage fields,
// synchronous active-low reset clears every field.
import mem_stage_pkg::*;

module exmem_reg #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              vld_d,
  input  logic              rd_d,
  input  logic              wr_d,
  input  logic              br_d,
  input  logic              zero_d,
  input  logic [DATA_W-1:0] alu_d,
  input  logic [DATA_W-1:0] wdata_d,
  input  logic [DATA_W-1:0] pcb_d,
  output logic              vld_p0,
  output logic              rd_p0,
  output logic              wr_p0,
  output logic              br_p0,
  output logic              zero_p0,
  output logic [DATA_W-1:0] alu_p0,
  output logic [DATA_W-1:0] wdata_p0,
  output logic [DATA_W-1:0] pcb_p0
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0   <= 1'b0;
      rd_p0    <= 1'b0;
      wr_p0    <= 1'b0;
      br_p0    <= 1'b0;
      zero_p0  <= 1'b0;
      alu_p0   <= '0;
      wdata_p0 <= '0;
      pcb_p0   <= '0;
    end else if (en) begin
      vld_p0   <= vld_d;
      rd_p0    <= rd_d & vld_d;
      wr_p0    <= wr_d & vld_d;
      br_p0    <= br_d & vld_d;
      zero_p0  <= zero_d;
      alu_p0   <= alu_d;
      wdata_p0 <= wdata_d;
      pcb_p0   <= pcb_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, req/ack data-memory FSM, branch resolution.
// Optional MEM_TIMEOUT_EN adds an ACCESS watchdog and the memFault_M output.
import mem_stage_pkg::*;

module mem_access_stage #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_E,
  input  logic              memRead_E,
  input  logic              memWrite_E,
  input  logic              branch_E,
  input  logic [DATA_W-1:0] aluResult_E,
  input  logic [DATA_W-1:0] writeData_E,
  input  logic [DATA_W-1:0] PCBranch_E,
  input  logic              zero_E,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              stall_M,
  output logic              valid_M,
  output logic [DATA_W-1:0] readData_M,
  output logic [DATA_W-1:0] aluResult_M,
  output logic [DATA_W-1:0] PCBranch_M,
  output logic              PCSrc_M,
`ifdef MEM_TIMEOUT_EN
  output logic              memFault_M,
`endif
  output logic              misaligned_M
);

  state_t            state, state_n;
  logic              vld_p0, rd_p0, wr_p0, br_p0, zero_p0;
  logic [DATA_W-1:0] alu_p0, wdata_p0, pcb_p0;
  logic              pend_p1;
  logic              in_access, timeout, done, capture;
  logic              acc_e, rep_e;

  assign acc_e = valid_E & (memRead_E | memWrite_E) & is_aligned(aluResult_E[2:0]);
  assign rep_e = valid_E & ~acc_e;

  assign in_access = (state == ACCESS);
  assign done      = in_access & (memAck | timeout);
  // pend_p1 holds upstream for one cycle when a completing access and a
  // newly captured non-access op would both need the single result slot.
  assign stall_M   = (in_access & ~memAck & ~timeout) | pend_p1;
  assign capture   = ~stall_M;

  assign memReq   = in_access & vld_p0;
  assign memWe    = memReq & wr_p0;
  assign memAddr  = memReq ? alu_p0   : '0;
  assign memWdata = memReq ? wdata_p0 : '0;

  // ---- EX -> MEM boundary ----
  exmem_reg #(.DATA_W(DATA_W)) u_exmem (
    .clk      (clk),
    .reset    (reset),
    .en       (capture),
    .vld_d    (valid_E),
    .rd_d     (memRead_E),
    .wr_d     (memWrite_E),
    .br_d     (branch_E),
    .zero_d   (zero_E),
    .alu_d    (aluResult_E),
    .wdata_d  (writeData_E),
    .pcb_d    (PCBranch_E),
    .vld_p0   (vld_p0),
    .rd_p0    (rd_p0),
    .wr_p0    (wr_p0),
    .br_p0    (br_p0),
    .zero_p0  (zero_p0),
    .alu_p0   (alu_p0),
    .wdata_p0 (wdata_p0),
    .pcb_p0   (pcb_p0)
  );

`ifdef MEM_TIMEOUT_EN
  logic [31:0] to_cnt_p0;
  assign timeout = in_access & ~memAck & (to_cnt_p0 == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset || !in_access || memAck || timeout) to_cnt_p0 <= '0;
    else                                           to_cnt_p0 <= to_cnt_p0 + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (capture) state_n = acc_e ? ACCESS : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // ---- MEM result boundary ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_M      <= 1'b0;
      PCSrc_M      <= 1'b0;
      misaligned_M <= 1'b0;
      pend_p1      <= 1'b0;
      readData_M   <= '0;
      aluResult_M  <= '0;
      PCBranch_M   <= '0;
`ifdef MEM_TIMEOUT_EN
      memFault_M   <= 1'b0;
`endif
    end else begin
      valid_M      <= 1'b0;
      PCSrc_M      <= 1'b0;
      misaligned_M <= 1'b0;
      pend_p1      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      memFault_M   <= 1'b0;
`endif
      if (done) begin
        valid_M     <= 1'b1;
        aluResult_M <= alu_p0;
        PCBranch_M  <= pcb_p0;
        readData_M  <= (memAck & rd_p0 & ~wr_p0) ? memRdata : '0;
        pend_p1     <= rep_e;
`ifdef MEM_TIMEOUT_EN
        memFault_M  <= timeout;
`endif
      end else if (pend_p1) begin
        valid_M      <= 1'b1;
        aluResult_M  <= alu_p0;
        PCBranch_M   <= pcb_p0;
        PCSrc_M      <= br_p0 & zero_p0;
        misaligned_M <= rd_p0 | wr_p0;
        readData_M   <= '0;
      end else if (capture && rep_e) begin
        valid_M      <= 1'b1;
        aluResult_M  <= aluResult_E;
        PCBranch_M   <= PCBranch_E;
        PCSrc_M      <= branch_E & zero_E;
        misaligned_M <= memRead_E | memWrite_E;
        readData_M   <= '0;
      end
    end
  end

endmodule
